// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: PC-register stream, instruction-bus handshake and IF/ID buffer port.
// master = fetch stage, slave = its surroundings (PC register, bus, decode).
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              flush;
    logic              pc_stall;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              id_excp_adel;
    logic              id_ready;

    modport master (
        input  pc, ce, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        output pc_stall, inst_req, inst_addr, id_valid, id_pc, id_inst, id_excp_adel
    );

    modport slave (
        output pc, ce, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        input  pc_stall, inst_req, inst_addr, id_valid, id_pc, id_inst, id_excp_adel
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one bus read per accepted PC, one-entry IF/ID buffer plus skid,
// flushes absorbed without breaking the request/data handshake.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  fif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REQ_KILL,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              excp;
    } entry_t;

    state_e            state_q, state_d;
    logic              inst_req_q, inst_req_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              id_valid_q, id_valid_d;
    entry_t            buf_q, buf_d;
    entry_t            skid_q, skid_d;

    logic              buf_free;
    logic              wr_en;
    entry_t            wr_entry;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        inst_req_d  = inst_req_q;
        inst_addr_d = inst_addr_q;
        req_pc_d    = req_pc_q;
        skid_d      = skid_q;
        buf_d       = buf_q;
        id_valid_d  = id_valid_q;
        buf_free    = !id_valid_q || fif.id_ready;
        wr_en       = 1'b0;
        wr_entry    = '{pc: req_pc_q, inst: fif.inst_rdata, excp: 1'b0};

        case (state_q)
            S_IDLE: begin
                if (fif.ce && !fif.flush) begin
                    req_pc_d = fif.pc;
                    if (fif.pc[1:0] == 2'b00) begin
                        inst_req_d  = 1'b1;
                        inst_addr_d = fif.pc;
                        state_d     = S_REQ;
                    end else begin
                        // Misaligned PC never reaches the bus; decode sees a NOP tagged with the exception.
                        wr_entry = '{pc: fif.pc, inst: NOP_INST, excp: 1'b1};
                        if (buf_free) begin
                            wr_en = 1'b1;
                        end else begin
                            skid_d  = wr_entry;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_REQ: begin
                if (fif.inst_addr_ok) begin
                    inst_req_d = 1'b0;
                    state_d    = fif.flush ? S_DROP : S_WAIT;
                end else if (fif.flush) begin
                    state_d = S_REQ_KILL;
                end
            end
            S_REQ_KILL: begin
                if (fif.inst_addr_ok) begin
                    inst_req_d = 1'b0;
                    state_d    = S_DROP;
                end
            end
            S_WAIT: begin
                if (fif.flush) begin
                    state_d = fif.inst_data_ok ? S_IDLE : S_DROP;
                end else if (fif.inst_data_ok) begin
                    if (buf_free) begin
                        wr_en   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        skid_d  = wr_entry;
                        state_d = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (fif.inst_data_ok) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (fif.flush) begin
                    state_d = S_IDLE;
                end else if (buf_free) begin
                    wr_entry = skid_q;
                    wr_en    = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats a write, a write beats a drain.
        if (fif.flush) begin
            id_valid_d = 1'b0;
        end else if (wr_en) begin
            id_valid_d = 1'b1;
            buf_d      = wr_entry;
        end else if (fif.id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            inst_req_q  <= 1'b0;
            inst_addr_q <= '0;
            req_pc_q    <= '0;
            id_valid_q  <= 1'b0;
            buf_q       <= '0;
            skid_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            inst_req_q  <= inst_req_d;
            inst_addr_q <= inst_addr_d;
            req_pc_q    <= req_pc_d;
            id_valid_q  <= id_valid_d;
            buf_q       <= buf_d;
            skid_q      <= skid_d;
        end
    end

    assign fif.pc_stall     = fif.ce && !fif.flush && (state_q != S_IDLE);
    assign fif.inst_req     = inst_req_q;
    assign fif.inst_addr    = inst_addr_q;
    assign fif.id_valid     = id_valid_q;
    assign fif.id_pc        = buf_q.pc;
    assign fif.id_inst      = buf_q.inst;
    assign fif.id_excp_adel = buf_q.excp;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench plays PC register, instruction bus and decode.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inst_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .NOP_INST(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .fif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Zero-wait fetch: accept, addr_ok with the request, data_ok the cycle after.
    task automatic fetch_zw(input logic [31:0] a, input logic [31:0] d);
        bus.ce = 1'b1;
        bus.pc = a;
        tick();
        bus.ce = 1'b0;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = d;
        tick();
        bus.inst_data_ok = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst              = 1'b0;
        bus.pc           = '0;
        bus.ce           = 1'b0;
        bus.flush        = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        bus.id_ready     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_inst_req", bus.inst_req, 0);
        check("rst_inst_addr", bus.inst_addr, 0);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_pc", bus.id_pc, 0);
        check("rst_id_inst", bus.id_inst, 0);
        check("rst_id_excp", bus.id_excp_adel, 0);
        check("rst_pc_stall", bus.pc_stall, 0);
        rst = 1'b1;
        tick();

        // Zero-wait fetch with pc held by the PC register while stalled
        bus.id_ready = 1'b1;
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0000;
        #1 check("zw_stall_idle", bus.pc_stall, 0);
        tick();
        check("zw_req", bus.inst_req, 1);
        check("zw_addr", bus.inst_addr, 32'h0000_0000);
        check("zw_stall_req", bus.pc_stall, 1);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h3C01_0001;
        check("zw_req_drop", bus.inst_req, 0);
        check("zw_stall_wait", bus.pc_stall, 1);
        check("zw_no_valid_yet", bus.id_valid, 0);
        tick();
        bus.inst_data_ok = 1'b0;
        bus.ce = 1'b0;
        check("zw_valid", bus.id_valid, 1);
        check("zw_pc", bus.id_pc, 32'h0000_0000);
        check("zw_inst", bus.id_inst, 32'h3C01_0001);
        check("zw_excp", bus.id_excp_adel, 0);

        // Bus wait states: addr_ok delayed three cycles
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0004;
        tick();
        bus.ce = 1'b0;
        check("ws_drain", bus.id_valid, 0);
        for (int k = 0; k < 3; k++) begin
            check("ws_req_hold", bus.inst_req, 1);
            check("ws_addr_hold", bus.inst_addr, 32'h0000_0004);
            tick();
        end
        check("ws_req_at_ok", bus.inst_req, 1);
        check("ws_addr_at_ok", bus.inst_addr, 32'h0000_0004);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        check("ws_req_fall", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h8C22_0000;
        tick();
        bus.inst_data_ok = 1'b0;
        check("ws_valid", bus.id_valid, 1);
        check("ws_pc", bus.id_pc, 32'h0000_0004);
        check("ws_inst", bus.id_inst, 32'h8C22_0000);
        tick();
        check("ws_drained", bus.id_valid, 0);

        // Back-pressure: second word parks in the skid
        bus.id_ready = 1'b0;
        fetch_zw(32'h0000_0008, 32'h1111_1111);
        check("bp_first_valid", bus.id_valid, 1);
        check("bp_first_pc", bus.id_pc, 32'h0000_0008);
        fetch_zw(32'h0000_000C, 32'h2222_2222);
        check("bp_buf_kept_pc", bus.id_pc, 32'h0000_0008);
        check("bp_buf_kept_inst", bus.id_inst, 32'h1111_1111);
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0010;
        #1 check("bp_hold_stall", bus.pc_stall, 1);
        bus.ce = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        check("bp_skid_valid", bus.id_valid, 1);
        check("bp_skid_pc", bus.id_pc, 32'h0000_000C);
        check("bp_skid_inst", bus.id_inst, 32'h2222_2222);
        bus.ce = 1'b1;
        #1 check("bp_idle_stall", bus.pc_stall, 0);
        bus.ce = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        check("bp_drained", bus.id_valid, 0);

        // Flush while the request is pending: REQ_KILL then DROP
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0020;
        tick();
        bus.ce = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fk_req_held", bus.inst_req, 1);
        check("fk_addr_held", bus.inst_addr, 32'h0000_0020);
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0024;
        #1 check("fk_stall", bus.pc_stall, 1);
        bus.ce = 1'b0;
        tick();
        check("fk_req_held2", bus.inst_req, 1);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        check("fk_req_fall", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        tick();
        bus.inst_data_ok = 1'b0;
        check("fk_discard", bus.id_valid, 0);
        fetch_zw(32'h0000_0100, 32'h2442_0001);
        check("fk_next_valid", bus.id_valid, 1);
        check("fk_next_pc", bus.id_pc, 32'h0000_0100);
        check("fk_next_inst", bus.id_inst, 32'h2442_0001);

        // Flush during WAIT with no data yet: DROP swallows the late data
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0104;
        tick();
        bus.ce = 1'b0;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fw_req_low", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        tick();
        bus.inst_data_ok = 1'b0;
        check("fw_discard", bus.id_valid, 0);
        bus.ce = 1'b1;
        #1 check("fw_back_idle", bus.pc_stall, 0);
        bus.ce = 1'b0;

        // Misaligned PC: synthetic exception entry, no bus access
        bus.ce = 1'b1;
        bus.pc = 32'h0000_0002;
        tick();
        bus.ce = 1'b0;
        check("ma_no_req", bus.inst_req, 0);
        check("ma_valid", bus.id_valid, 1);
        check("ma_excp", bus.id_excp_adel, 1);
        check("ma_inst", bus.id_inst, 32'h0000_0000);
        check("ma_pc", bus.id_pc, 32'h0000_0002);
        tick();
        check("ma_no_req2", bus.inst_req, 0);
        check("ma_drained", bus.id_valid, 0);

        // Asynchronous reset in the middle of WAIT, then restart from the presented pc
        bus.id_ready = 1'b0;
        bus.ce = 1'b1;
        bus.pc = 32'h0000_01FE;
        tick();
        bus.pc = 32'h0000_0200;
        tick();
        check("ar_req", bus.inst_req, 1);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        check("ar_pre_valid", bus.id_valid, 1);
        check("ar_pre_stall", bus.pc_stall, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_req_low", bus.inst_req, 0);
        check("ar_valid_low", bus.id_valid, 0);
        check("ar_stall_low", bus.pc_stall, 0);
        check("ar_pc_clear", bus.id_pc, 0);
        tick();
        rst = 1'b1;
        tick();
        check("ar_restart_req", bus.inst_req, 1);
        check("ar_restart_addr", bus.inst_addr, 32'h0000_0200);
        bus.ce = 1'b0;
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h27BD_FFF8;
        tick();
        bus.inst_data_ok = 1'b0;
        check("ar_restart_valid", bus.id_valid, 1);
        check("ar_restart_pc", bus.id_pc, 32'h0000_0200);
        check("ar_restart_inst", bus.id_inst, 32'h27BD_FFF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the PC register's `pc`/`ce` stream and issues one instruction-bus read per accepted PC.
- Returns the fetched word with its PC through a one-entry output buffer plus one skid register to the IF/ID boundary.
- Back-pressures the PC register via `pc_stall`, and absorbs pipeline flushes without breaking the bus handshake.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- NOP_INST, 32'h00000000, word delivered with a misaligned-PC exception.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  fetch address from the PC register.
- ce  in  1  PC valid (chip enable) from the PC register.
- flush  in  1  kill all in-flight and buffered fetches this cycle.
- pc_stall  out  1  presented pc not accepted this cycle; PC register must hold.
- inst_req  out  1  bus request, registered.
- inst_addr  out  ADDR_W  bus address, registered, stable while inst_req=1.
- inst_addr_ok  in  1  bus accepted the request.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  DATA_W  read data.
- id_valid  out  1  output buffer holds an instruction.
- id_pc  out  ADDR_W  PC of the buffered instruction.
- id_inst  out  DATA_W  buffered instruction word.
- id_excp_adel  out  1  buffered entry is a misaligned-fetch exception.
- id_ready  in  1  decode consumes the buffer this cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; inst_req=0; inst_addr=0; id_valid=0; id_pc=0; id_inst=0; id_excp_adel=0; skid empty.
- buf_free = !id_valid || id_ready.
- Bus rules:
  - inst_req, once raised, holds with constant inst_addr until inst_addr_ok.
  - At most one transaction is outstanding.
  - inst_data_ok arrives no earlier than the cycle after inst_addr_ok.
- pc_stall = ce && !flush && (state != IDLE). pc_stall is combinational.
- State machine: IDLE, REQ, REQ_KILL, WAIT, DROP, HOLD.
- IDLE:
  - Accept when ce=1 && flush=0; latch pc as req_pc.
  - If pc[1:0]==0: next cycle inst_req=1, inst_addr=pc, go to REQ.
  - If pc[1:0]!=0: no bus access. Synthetic entry {pc, NOP_INST, excp=1}: written to the buffer next cycle if buf_free (stay IDLE), else to the skid (go to HOLD).
- REQ:
  - inst_addr_ok=1 -> WAIT; inst_req=0 next cycle.
  - flush=1 && !inst_addr_ok -> REQ_KILL.
  - flush=1 && inst_addr_ok -> DROP.
- REQ_KILL: inst_req stays 1 until inst_addr_ok, then DROP.
- WAIT:
  - inst_data_ok=1 && flush=0: entry {req_pc, inst_rdata, 0} goes to the buffer if buf_free (-> IDLE), else to the skid (-> HOLD).
  - flush=1 && inst_data_ok=1 -> discard, go to IDLE.
  - flush=1 && inst_data_ok=0 -> DROP.
- DROP: inst_data_ok=1 -> discard, go to IDLE. The PC register is not stalled by flush, but pc_stall stays 1 until IDLE.
- HOLD:
  - id_ready=1 -> skid moves to the buffer next cycle, go to IDLE.
  - flush=1 -> skid discarded, go to IDLE.
- Output buffer:
  - id_ready && id_valid with no new write -> id_valid=0 next cycle.
  - A write takes priority over drain: simultaneous drain and write yields id_valid=1 with the new entry.
- flush clears id_valid next cycle, overriding any write in the same cycle.
- Latency (zero-wait bus): PC accepted in cycle T -> inst_req in T+1 -> addr_ok in T+1 -> data_ok in T+2 -> id_valid in T+3.
- Throughput: at most one accepted PC per transaction; no speculative next-PC request.
- Asynchronous reset mid-transaction drops the request immediately. The bus is reset by the same rst, so no stale data_ok follows.

Test Plan:
- Zero-wait fetch: ce=1, pc=0x00000000, addr_ok same cycle as req, data_ok next cycle with 0x3C010001 -> id_valid=1 with id_pc=0, id_inst=0x3C010001 three cycles after accept; pc_stall=1 for the two intervening cycles.
- Bus wait states: addr_ok delayed 3 cycles -> inst_req and inst_addr=0x00000004 held constant across all 3 cycles; inst_req falls the cycle after addr_ok.
- Back-pressure: id_ready=0, first fetch buffered, second fetch data_ok -> state HOLD, second word kept in the skid. id_ready=1 for one cycle -> buffer shows the second word next cycle, state IDLE.
- Flush in REQ_KILL/WAIT: flush while req pending -> inst_req held until addr_ok. Returning data 0xDEADBEEF is discarded; id_valid stays 0; next pc 0x00000100 fetched normally afterwards.
- Misaligned PC: pc=0x00000002, ce=1 -> inst_req never asserted; id_valid=1, id_excp_adel=1, id_inst=0x00000000, id_pc=0x00000002 next cycle.
- Reset mid-WAIT: rst=0 asynchronously -> inst_req, id_valid, pc_stall = 0 immediately. After release, fetch restarts from the presented pc.
